// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic ops plus an iterative shift-add
// multiplier and restoring divider, behind valid/ready handshakes on both sides.
module multicycle_alu #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [3:0]       alu_signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_UDIV  = 4'b1001;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  // MUL: r_x accumulator, r_y shifted multiplicand, r_z shifted multiplier.
  // UDIV: r_x remainder, r_y dividend/quotient shift register, r_z divisor.
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;

  logic             w_accept;
  logic             w_consume;
  logic             w_last;
  logic             w_multi;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_c;
  logic             w_sc_v;
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic [WIDTH-1:0] w_z_nxt;
  logic [WIDTH-1:0] w_mc_result;

  function automatic logic [1:0] nz_of(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], (v == ZERO_W)};
  endfunction

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign flags      = r_flags;

  assign w_accept  = in_valid && r_in_ready;
  assign w_consume = r_out_valid && out_ready;
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_multi   = (alu_signal == OP_MUL) || (alu_signal == OP_UDIV);
  assign w_sum     = {1'b0, data_a} + {1'b0, data_b};
  assign w_diff    = {1'b0, data_a} - {1'b0, data_b};

  // Single-cycle operation results and carry/overflow
  always_comb begin
    w_sc_result = ZERO_W;
    w_sc_c      = 1'b0;
    w_sc_v      = 1'b0;
    case (alu_signal)
      OP_AND:   w_sc_result = data_a & data_b;
      OP_ORR:   w_sc_result = data_a | data_b;
      OP_ADD: begin
        w_sc_result = w_sum[WIDTH-1:0];
        w_sc_c      = w_sum[WIDTH];
        w_sc_v      = (data_a[WIDTH-1] == data_b[WIDTH-1]) && (w_sum[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_result = w_diff[WIDTH-1:0];
        w_sc_c      = ~w_diff[WIDTH];
        w_sc_v      = (data_a[WIDTH-1] != data_b[WIDTH-1]) && (w_diff[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_PASSB: w_sc_result = data_b;
      OP_NOR:   w_sc_result = ~(data_a | data_b);
      default:  w_sc_result = ZERO_W;
    endcase
  end

  // One iteration step of the multiplier or restoring divider
  always_comb begin
    w_shift_rem = {r_x, r_y[WIDTH-1]};
    w_trial     = w_shift_rem - {1'b0, r_z};
    w_fits      = ~w_trial[WIDTH];
    if (r_op == OP_MUL) begin
      w_x_nxt = r_z[0] ? (r_x + r_y) : r_x;
      w_y_nxt = {r_y[WIDTH-2:0], 1'b0};
      w_z_nxt = {1'b0, r_z[WIDTH-1:1]};
    end else begin
      w_x_nxt = w_fits ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
      w_y_nxt = {r_y[WIDTH-2:0], w_fits};
      w_z_nxt = r_z;
    end
    if (r_op == OP_MUL) begin
      w_mc_result = w_x_nxt;
    end else if (r_z == ZERO_W) begin
      w_mc_result = ZERO_W;
    end else begin
      w_mc_result = w_y_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_multi ? S_BUSY : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        if (w_consume) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= ZERO_W;
      r_flags  <= 4'b0000;
      r_cnt    <= CNT_ZERO;
      r_op     <= 4'b0000;
      r_x      <= ZERO_W;
      r_y      <= ZERO_W;
      r_z      <= ZERO_W;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= alu_signal;
            r_cnt <= CNT_ZERO;
            if (w_multi) begin
              r_x <= ZERO_W;
              r_y <= data_a;
              r_z <= data_b;
            end else begin
              r_result <= w_sc_result;
              r_flags  <= {nz_of(w_sc_result), w_sc_c, w_sc_v};
            end
          end
        end
        S_BUSY: begin
          r_x   <= w_x_nxt;
          r_y   <= w_y_nxt;
          r_z   <= w_z_nxt;
          r_cnt <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_result <= w_mc_result;
            r_flags  <= {nz_of(w_mc_result), 2'b00};
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: a 64-bit and an 8-bit instance driven
// by directed and random requests, checked against a behavioural arithmetic model.
module tb_multicycle_alu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        w_iv, w_ir, w_ov, w_or;
  logic [63:0] w_a, w_b, w_res;
  logic [3:0]  w_op, w_fl;
  logic        n_iv, n_ir, n_ov, n_or;
  logic [7:0]  n_a, n_b, n_res;
  logic [3:0]  n_op, n_fl;

  multicycle_alu #(.WIDTH(64), .CNT_W(7)) u_wide (
    .clk(clk), .reset(reset), .in_valid(w_iv), .in_ready(w_ir),
    .data_a(w_a), .data_b(w_b), .alu_signal(w_op), .out_valid(w_ov),
    .out_ready(w_or), .alu_result(w_res), .flags(w_fl)
  );

  multicycle_alu #(.WIDTH(8), .CNT_W(4)) u_narrow (
    .clk(clk), .reset(reset), .in_valid(n_iv), .in_ready(n_ir),
    .data_a(n_a), .data_b(n_b), .alu_signal(n_op), .out_valid(n_ov),
    .out_ready(n_or), .alu_result(n_res), .flags(n_fl)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] last_w = 64'd0;
  logic [63:0] last_n = 64'd0;
  logic [3:0] op_codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                               4'b0111, 4'b1100, 4'b1000, 4'b1001};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int w, input logic [3:0] op, input logic [63:0] a_in,
                                input logic [63:0] b_in, output logic [63:0] r, output logic [3:0] f);
    logic [63:0] mask, a, b;
    logic [64:0] s;
    logic c, v;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0] & mask;
        c = s[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'b0110: begin
        r = (a - b) & mask;
        c = (a >= b);
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      4'b0111: r = b;
      4'b1100: r = ~(a | b) & mask;
      4'b1000: r = (a * b) & mask;
      4'b1001: r = (b == 64'd0) ? 64'd0 : a / b;
      default: r = 64'd0;
    endcase
    f = {r[w-1], (r == 64'd0), c, v};
  endfunction

  function automatic logic [63:0] get_ir(input bit wide);
    return wide ? {63'd0, w_ir} : {63'd0, n_ir};
  endfunction
  function automatic logic [63:0] get_ov(input bit wide);
    return wide ? {63'd0, w_ov} : {63'd0, n_ov};
  endfunction
  function automatic logic [63:0] get_res(input bit wide);
    return wide ? w_res : {56'd0, n_res};
  endfunction
  function automatic logic [63:0] get_fl(input bit wide);
    return wide ? {60'd0, w_fl} : {60'd0, n_fl};
  endfunction

  task automatic drive(input bit wide, input logic iv, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] op);
    if (wide) begin
      w_iv = iv; w_a = a; w_b = b; w_op = op;
    end else begin
      n_iv = iv; n_a = a[7:0]; n_b = b[7:0]; n_op = op;
    end
  endtask

  task automatic set_or(input bit wide, input logic v);
    if (wide) w_or = v;
    else n_or = v;
  endtask

  task automatic run_op(input bit wide, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int hold, input string tag);
    int w, lat, budget, exp_lat;
    logic [63:0] er, prev;
    logic [3:0] ef;
    w = wide ? 64 : 8;
    model(w, op, a, b, er, ef);
    exp_lat = (op == 4'b1000 || op == 4'b1001) ? w + 1 : 1;
    prev = wide ? last_w : last_n;
    budget = 0;
    while (get_ir(wide) != 64'd1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_in_ready_idle"}, get_ir(wide), 64'd1);
    drive(wide, 1'b1, a, b, op);
    set_or(wide, (hold == 0));
    @(negedge clk);
    lat = 1;
    while (get_ov(wide) != 64'd1 && lat < 200) begin
      check({tag, "_busy_in_ready"}, get_ir(wide), 64'd0);
      check({tag, "_busy_result_held"}, get_res(wide), prev);
      drive(wide, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom_range(0, 15)));
      @(negedge clk);
      lat++;
    end
    drive(wide, 1'b0, 64'd0, 64'd0, 4'b0000);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, get_res(wide), er);
    check({tag, "_flags"}, get_fl(wide), {60'd0, ef});
    for (int k = 0; k < hold; k++) begin
      drive(wide, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0010);
      @(negedge clk);
      check({tag, "_hold_valid"}, get_ov(wide), 64'd1);
      check({tag, "_hold_result"}, get_res(wide), er);
      check({tag, "_hold_flags"}, get_fl(wide), {60'd0, ef});
      check({tag, "_hold_in_ready"}, get_ir(wide), 64'd0);
    end
    drive(wide, 1'b0, 64'd0, 64'd0, 4'b0000);
    set_or(wide, 1'b1);
    @(negedge clk);
    check({tag, "_consumed_valid"}, get_ov(wide), 64'd0);
    check({tag, "_consumed_in_ready"}, get_ir(wide), 64'd1);
    if (wide) last_w = er;
    else last_n = er;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 64'd0, 64'd0, 4'b0000);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'b0000);
    w_or = 1'b1;
    n_or = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_in_ready", get_ir(d == 1), 64'd1);
      check("reset_out_valid", get_ov(d == 1), 64'd0);
      check("reset_result", get_res(d == 1), 64'd0);
      check("reset_flags", get_fl(d == 1), 64'd0);
    end

    run_op(1'b1, 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, "add_overflow");
    check("add_overflow_exact", last_w, 64'h8000_0000_0000_0000);
    run_op(1'b1, 4'b0110, 64'd5, 64'd5, 0, "sub_equal");
    run_op(1'b1, 4'b0110, 64'd3, 64'd5, 0, "sub_borrow");
    check("sub_borrow_exact", last_w, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(1'b0, 4'b1000, 64'h0D, 64'h13, 0, "mul8");
    check("mul8_exact", last_n, 64'hF7);
    run_op(1'b0, 4'b1001, 64'd200, 64'd7, 0, "udiv8");
    check("udiv8_exact", last_n, 64'd28);
    run_op(1'b0, 4'b1001, 64'd200, 64'd0, 0, "udiv8_by_zero");
    run_op(1'b0, 4'b0000, 64'hF0, 64'h3C, 5, "and_backpressure");
    run_op(1'b1, 4'b1000, 64'h1234_5678_9ABC_DEF1, 64'h0FED_CBA9_8765_4321, 0, "mul64");
    run_op(1'b1, 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1, "udiv64");

    // Abort a multiply in its fourth BUSY cycle
    drive(1'b0, 1'b1, 64'h0D, 64'h13, 4'b1000);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'b0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid", get_ov(1'b0), 64'd0);
    check("abort_result", get_res(1'b0), 64'd0);
    check("abort_flags", get_fl(1'b0), 64'd0);
    check("abort_wide_result", get_res(1'b1), 64'd0);
    @(negedge clk);
    check("abort_in_ready", get_ir(1'b0), 64'd1);
    for (int k = 0; k < 12; k++) begin
      check("abort_no_result", get_ov(1'b0), 64'd0);
      @(negedge clk);
    end
    last_n = 64'd0;
    last_w = 64'd0;
    run_op(1'b0, 4'b0010, 64'd2, 64'd3, 0, "add_after_abort");
    check("add_after_abort_exact", last_n, 64'd5);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [63:0] b;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : op_codes[$urandom_range(0, 7)];
      b = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom);
      run_op(1'b0, op, 64'($urandom), b, $urandom_range(0, 2), "rand8");
    end
    for (int i = 0; i < 12; i++) begin
      logic [3:0] op;
      op = op_codes[$urandom_range(0, 7)];
      run_op(1'b1, op, {$urandom, $urandom}, {$urandom_range(0, 3) == 0 ? 32'd0 : $urandom, $urandom},
             $urandom_range(0, 1), "rand64");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width in bits, legal range 8..64, even.
REQ-002 SHALL have parameter CNT_W, default 7: iteration-counter width, SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: operation request present.
REQ-006 SHALL have port in_ready  output  1: block can accept a request this cycle.
REQ-007 SHALL have port data_a  input  WIDTH: operand A.
REQ-008 SHALL have port data_b  input  WIDTH: operand B.
REQ-009 SHALL have port alu_signal  input  4: operation select.
REQ-010 SHALL have port out_valid  output  1: result and flags valid.
REQ-011 SHALL have port out_ready  input  1: consumer takes the result this cycle.
REQ-012 SHALL have port alu_result  output  WIDTH: registered result.
REQ-013 SHALL have port flags  output  4: registered {N,Z,C,V}.

Function
REQ-014 SHALL decode alu_signal: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB (A-B), 0111 PASS B, 1100 NOR, 1000 MUL (low WIDTH bits of A*B, unsigned), 1001 UDIV (A/B, unsigned); any other code SHALL give result 0.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request when in_valid && in_ready, latching data_a, data_b, alu_signal on that edge; inputs SHALL be ignored at all other times.
REQ-017 For single-cycle codes (all except MUL, UDIV) SHALL go IDLE->DONE on accept, result and flags registered on the same edge: out_valid high the cycle after accept (latency 1).
REQ-018 For MUL and UDIV SHALL go IDLE->BUSY on accept, iterate one bit per cycle for exactly WIDTH cycles, then go BUSY->DONE: out_valid high WIDTH+1 cycles after accept.
REQ-019 MUL SHALL be shift-add over B bits LSB first; UDIV SHALL be restoring division, one quotient bit per cycle MSB first.
REQ-020 UDIV with B=0 SHALL complete with normal latency and yield result 0, flags Z=1, N=C=V=0.
REQ-021 In DONE, out_valid SHALL be 1 and alu_result/flags SHALL hold stable until out_valid && out_ready, then state SHALL return to IDLE on that edge.
REQ-022 SHALL NOT accept a new request in the cycle the result is consumed (no bypass); next accept earliest one cycle later.
REQ-023 out_valid, alu_result, flags SHALL not change while in BUSY except as stated; alu_result SHALL show the previous result until DONE.
REQ-024 Z SHALL be 1 iff result==0; N SHALL equal result[WIDTH-1], for all operations.
REQ-025 For ADD, C SHALL be carry-out of bit WIDTH-1 and V SHALL be signed overflow; for SUB, C SHALL be 1 iff no borrow (A>=B unsigned) and V SHALL be signed overflow of A-B.
REQ-026 For all operations other than ADD and SUB, C and V SHALL be 0.
REQ-027 Iteration counter SHALL be CNT_W bits, load 0 on accept, increment per BUSY cycle, with BUSY exit when it reaches WIDTH-1; it SHALL never wrap.

Reset
REQ-028 While reset is high on a rising edge, state SHALL become IDLE, out_valid 0, alu_result 0, flags 0000, counter 0; in_ready SHALL read 1 the cycle after reset deasserts.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation with no result ever presented; reset SHALL take priority over a simultaneous accept or consume.

Verification
REQ-030 WIDTH=64, ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1, out_ready=1 -> out_valid 1 cycle after accept, result 0x8000_0000_0000_0000, flags N=1 Z=0 C=0 V=1.
REQ-031 WIDTH=64, SUB A=5, B=5 -> result 0, flags N=0 Z=1 C=1 V=0; SUB A=3, B=5 -> result 0xFFFF_FFFF_FFFF_FFFE, N=1 C=0 V=0.
REQ-032 WIDTH=8, MUL A=0x0D, B=0x13 -> out_valid exactly 9 cycles after accept, result 0xF7, flags N=1 Z=0 C=0 V=0; in_ready 0 throughout.
REQ-033 WIDTH=8, UDIV A=200, B=7 -> result 28 after 9 cycles; UDIV A=200, B=0 -> result 0, Z=1, same latency.
REQ-034 Backpressure: AND A=0xF0, B=0x3C with out_ready=0 for 5 cycles -> out_valid and result 0x30 held stable, in_ready 0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-MUL (cycle 4 of BUSY) -> next cycle IDLE, out_valid 0, result 0, flags 0; subsequent ADD 2+3 returns 5 at latency 1.
